// File: rtl/proc_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_arb_pkg
//  Description : Shared types for the processor/memory arbiter: requester
//                source IDs, default in-flight depth and the 4-byte memory
//                request/response message formats.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_mem_arb_pkg;

  // Default number of memory requests allowed in flight at once.
  localparam int unsigned DEFAULT_NUM_INFLIGHT = 4;

  // Requester identity, carried in the tag queue to steer responses.
  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage
`default_nettype wire

// File: rtl/proc_mem_arb_tagq.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_arb_tagq
//  Description : Circular-buffer FIFO of requester source IDs, one entry per
//                outstanding memory request. Pointers carry one extra wrap
//                bit so full and empty are distinguishable.
//  Ports       : clk, reset (async, active-low)
//                push / push_src   : enqueue a source ID
//                pop               : dequeue the head entry
//                head_src          : source ID at the head
//                full / empty      : occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module proc_mem_arb_tagq
  import proc_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_NUM_INFLIGHT
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  src_e push_src,
  input  logic pop,
  output src_e head_src,
  output logic full,
  output logic empty
);

  localparam int unsigned     PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  PTR_ONE = 1;

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  src_e           r_slots [DEPTH];

  // Storage needs no reset: entries are only read while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      r_slots[r_wr_ptr[PTR_W-1:0]] <= push_src;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign head_src = r_slots[r_rd_ptr[PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/proc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : proc_mem_arbiter
//  Description : Merges instruction-fetch and data request streams onto one
//                in-order memory port with round-robin arbitration, then
//                steers responses back using a queue of source tags. Fetch
//                responses can be squashed via imem_drop.
//  Ports       : clk, reset (async, active-low)
//                imem_req_*  / dmem_req_*  : requester val/rdy/msg inputs
//                mem_req_*                 : shared memory request port
//                mem_resp_*                : shared memory response port
//                imem_resp_* / dmem_resp_* : per-source response streams
//                imem_drop                 : squash one outstanding fetch
//  Revision    : 1.0  initial release
// ============================================================================
module proc_mem_arbiter
  import proc_mem_arb_pkg::*;
#(
  parameter int unsigned p_num_inflight = DEFAULT_NUM_INFLIGHT
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         imem_req_val,
  output logic         imem_req_rdy,
  input  mem_req_4B_t  imem_req_msg,

  input  logic         dmem_req_val,
  output logic         dmem_req_rdy,
  input  mem_req_4B_t  dmem_req_msg,

  output logic         mem_req_val,
  input  logic         mem_req_rdy,
  output mem_req_4B_t  mem_req_msg,

  input  logic         mem_resp_val,
  output logic         mem_resp_rdy,
  input  mem_resp_4B_t mem_resp_msg,

  output logic         imem_resp_val,
  input  logic         imem_resp_rdy,
  output mem_resp_4B_t imem_resp_msg,

  output logic         dmem_resp_val,
  input  logic         dmem_resp_rdy,
  output mem_resp_4B_t dmem_resp_msg,

  input  logic         imem_drop
);

  localparam int unsigned       CNT_W   = $clog2(p_num_inflight + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(p_num_inflight);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  src_e             r_last_grant;
  logic [CNT_W-1:0] r_drop_cnt;

  src_e w_grant;
  src_e w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_discard;
  logic w_drop_consume;

  // ---------------------------------------------------------------- request
  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_grant = SRC_IMEM;
    if (imem_req_val && dmem_req_val) begin
      w_grant = (r_last_grant == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
    end else if (dmem_req_val) begin
      w_grant = SRC_DMEM;
    end
  end

  // The reset term forces every handshake output low while reset is held,
  // independent of the (already cleared) queue flags.
  assign mem_req_val  = reset && !w_full &&
                        ((w_grant == SRC_DMEM) ? dmem_req_val : imem_req_val);
  assign imem_req_rdy = reset && !w_full && mem_req_rdy && (w_grant == SRC_IMEM);
  assign dmem_req_rdy = reset && !w_full && mem_req_rdy && (w_grant == SRC_DMEM);
  assign mem_req_msg  = (w_grant == SRC_DMEM) ? dmem_req_msg : imem_req_msg;

  assign w_push = mem_req_val && mem_req_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= SRC_IMEM;
    end else if (w_push) begin
      r_last_grant <= w_grant;
    end
  end

  // --------------------------------------------------------------- tag queue
  proc_mem_arb_tagq #(
    .DEPTH (p_num_inflight)
  ) u_tagq (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .push_src (w_grant),
    .pop      (w_pop),
    .head_src (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // --------------------------------------------------------------- response
  // A fetch response is squashed if a drop is pending or arrives this cycle.
  assign w_discard = !w_empty && (w_head == SRC_IMEM) &&
                     ((r_drop_cnt != '0) || imem_drop);

  always_comb begin
    mem_resp_rdy  = 1'b0;
    imem_resp_val = 1'b0;
    dmem_resp_val = 1'b0;
    if (reset && !w_empty) begin
      if (w_head == SRC_DMEM) begin
        mem_resp_rdy  = dmem_resp_rdy;
        dmem_resp_val = mem_resp_val;
      end else if (w_discard) begin
        mem_resp_rdy  = 1'b1;
      end else begin
        mem_resp_rdy  = imem_resp_rdy;
        imem_resp_val = mem_resp_val;
      end
    end
  end

  assign imem_resp_msg = mem_resp_msg;
  assign dmem_resp_msg = mem_resp_msg;

  assign w_pop          = mem_resp_val && mem_resp_rdy;
  assign w_drop_consume = w_pop && w_discard;

  // A pulse arriving together with a discard cancels out, which also covers
  // the case of a pulse consumed directly while the counter is zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (imem_drop && !w_drop_consume) begin
      if (r_drop_cnt != CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_ONE;
    end else if (w_drop_consume && !imem_drop) begin
      r_drop_cnt <= r_drop_cnt - CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_mem_arbiter
//  Description : Self-checking bench for proc_mem_arbiter. A queue-based
//                reference model is compared against the DUT every cycle,
//                and directed scenarios pin specific expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_proc_mem_arbiter;
  import proc_mem_arb_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         imem_req_val, imem_req_rdy;
  mem_req_4B_t  imem_req_msg;
  logic         dmem_req_val, dmem_req_rdy;
  mem_req_4B_t  dmem_req_msg;
  logic         mem_req_val, mem_req_rdy;
  mem_req_4B_t  mem_req_msg;
  logic         mem_resp_val, mem_resp_rdy;
  mem_resp_4B_t mem_resp_msg;
  logic         imem_resp_val, imem_resp_rdy;
  mem_resp_4B_t imem_resp_msg;
  logic         dmem_resp_val, dmem_resp_rdy;
  mem_resp_4B_t dmem_resp_msg;
  logic         imem_drop;

  proc_mem_arbiter #(.p_num_inflight(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_val  (imem_req_val),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_msg  (imem_req_msg),
    .dmem_req_val  (dmem_req_val),
    .dmem_req_rdy  (dmem_req_rdy),
    .dmem_req_msg  (dmem_req_msg),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_msg   (mem_req_msg),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_rdy  (mem_resp_rdy),
    .mem_resp_msg  (mem_resp_msg),
    .imem_resp_val (imem_resp_val),
    .imem_resp_rdy (imem_resp_rdy),
    .imem_resp_msg (imem_resp_msg),
    .dmem_resp_val (dmem_resp_val),
    .dmem_resp_rdy (dmem_resp_rdy),
    .dmem_resp_msg (dmem_resp_msg),
    .imem_drop     (imem_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------ reference model
  // Outstanding requests are a FIFO of sources; responses return in order.
  src_e mq[$];
  int   mdrop;
  src_e mlast;
  src_e e_gnt;
  bit   e_full, e_empty, e_mrv, e_irdy, e_drdy, e_mrr, e_irv, e_drv, e_disc, e_pop;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_mem_req_val",  32'(mem_req_val),   32'd0);
      chk("rst_imem_req_rdy", 32'(imem_req_rdy),  32'd0);
      chk("rst_dmem_req_rdy", 32'(dmem_req_rdy),  32'd0);
      chk("rst_mem_resp_rdy", 32'(mem_resp_rdy),  32'd0);
      chk("rst_imem_resp_val",32'(imem_resp_val), 32'd0);
      chk("rst_dmem_resp_val",32'(dmem_resp_val), 32'd0);
      mq.delete();
      mdrop = 0;
      mlast = SRC_IMEM;
    end else begin
      e_full  = (mq.size() == N);
      e_empty = (mq.size() == 0);
      if (imem_req_val && dmem_req_val) e_gnt = (mlast == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
      else                              e_gnt = dmem_req_val ? SRC_DMEM : SRC_IMEM;
      e_mrv  = ((e_gnt == SRC_DMEM) ? dmem_req_val : imem_req_val) && !e_full;
      e_irdy = (e_gnt == SRC_IMEM) && mem_req_rdy && !e_full;
      e_drdy = (e_gnt == SRC_DMEM) && mem_req_rdy && !e_full;
      e_disc = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_mrr = 1'b0;
      if (!e_empty) begin
        if (mq[0] == SRC_DMEM) begin
          e_drv = mem_resp_val;
          e_mrr = dmem_resp_rdy;
        end else begin
          e_disc = (mdrop > 0) || imem_drop;
          e_irv  = mem_resp_val && !e_disc;
          e_mrr  = e_disc ? 1'b1 : imem_resp_rdy;
        end
      end
      chk("mdl_mem_req_val",   32'(mem_req_val),   32'(e_mrv));
      chk("mdl_imem_req_rdy",  32'(imem_req_rdy),  32'(e_irdy));
      chk("mdl_dmem_req_rdy",  32'(dmem_req_rdy),  32'(e_drdy));
      chk("mdl_mem_resp_rdy",  32'(mem_resp_rdy),  32'(e_mrr));
      chk("mdl_imem_resp_val", 32'(imem_resp_val), 32'(e_irv));
      chk("mdl_dmem_resp_val", 32'(dmem_resp_val), 32'(e_drv));
      if (e_mrv)
        chk("mdl_req_addr", mem_req_msg.addr,
            (e_gnt == SRC_DMEM) ? dmem_req_msg.addr : imem_req_msg.addr);
      if (e_irv) chk("mdl_imem_resp_data", imem_resp_msg.data, mem_resp_msg.data);
      if (e_drv) chk("mdl_dmem_resp_data", dmem_resp_msg.data, mem_resp_msg.data);
      // advance model state for the coming edge
      e_pop = mem_resp_val && e_mrr;
      if (e_pop) void'(mq.pop_front());
      if (e_mrv && mem_req_rdy) begin
        mq.push_back(e_gnt);
        mlast = e_gnt;
      end
      if (imem_drop && !(e_pop && e_disc)) mdrop = (mdrop < N) ? mdrop + 1 : N;
      else if (!imem_drop && e_pop && e_disc) mdrop = mdrop - 1;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] exp_addr [4];
  logic        exp_d    [4];

  initial begin
    exp_addr = '{32'h1000, 32'h100, 32'h1004, 32'h104};
    exp_d    = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b0;
    imem_req_msg = '0; dmem_req_msg = '0; mem_resp_msg = '0;
    imem_req_val = 1'b1; dmem_req_val = 1'b1; mem_req_rdy = 1'b1;
    mem_resp_val = 1'b1; imem_resp_rdy = 1'b1; dmem_resp_rdy = 1'b1;
    imem_drop = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_mem_req_val",  32'(mem_req_val),  32'd0);
    chk("reset_imem_req_rdy", 32'(imem_req_rdy), 32'd0);
    chk("reset_mem_resp_rdy", 32'(mem_resp_rdy), 32'd0);
    imem_req_val = 1'b0; dmem_req_val = 1'b0; mem_resp_val = 1'b0;
    tick();
    reset = 1'b1;

    // Round-robin from reset: D, I, D, I
    imem_req_msg.addr = 32'h100;
    dmem_req_msg.addr = 32'h1000;
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_dmem_rdy", 32'(dmem_req_rdy), 32'(exp_d[i]));
      chk("rr_addr",     mem_req_msg.addr,  exp_addr[i]);
      tick();
      if (exp_d[i]) dmem_req_msg.addr = dmem_req_msg.addr + 32'd4;
      else          imem_req_msg.addr = imem_req_msg.addr + 32'd4;
    end
    #1;
    chk("rr_full_block", 32'(mem_req_val), 32'd0);
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    mem_resp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_resp_msg.data = 32'h50 + 32'(i);
      #1;
      chk("rr_resp_dmem", 32'(dmem_resp_val), 32'(exp_d[i]));
      chk("rr_resp_imem", 32'(imem_resp_val), 32'(!exp_d[i]));
      tick();
    end
    mem_resp_val = 1'b0;

    // Tag queue full blocks the 5th fetch, no bypass on a same-cycle pop
    imem_req_msg.addr = 32'h300;
    imem_req_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_imem_rdy", 32'(imem_req_rdy), 32'd1);
      tick();
      imem_req_msg.addr = imem_req_msg.addr + 32'd4;
    end
    #1;
    chk("full_imem_rdy", 32'(imem_req_rdy), 32'd0);
    chk("full_mem_val",  32'(mem_req_val),  32'd0);
    tick();
    mem_resp_val = 1'b1;
    mem_resp_msg.data = 32'h60;
    #1;
    chk("no_bypass_rdy", 32'(imem_req_rdy), 32'd0);
    chk("no_bypass_pop", 32'(mem_resp_rdy), 32'd1);
    tick();
    mem_resp_val = 1'b0;
    #1;
    chk("after_pop_rdy", 32'(imem_req_rdy), 32'd1);
    chk("after_pop_addr", mem_req_msg.addr, 32'h310);
    tick();
    imem_req_val = 1'b0;
    mem_resp_val = 1'b1;
    repeat (4) begin
      #1;
      chk("drain_imem_val", 32'(imem_resp_val), 32'd1);
      tick();
    end
    mem_resp_val = 1'b0;

    // Response steering
    imem_req_val = 1'b1; imem_req_msg.addr = 32'h200;
    #1;
    chk("steer_addr_i", mem_req_msg.addr, 32'h200);
    tick();
    imem_req_val = 1'b0;
    dmem_req_val = 1'b1; dmem_req_msg.addr = 32'h1000;
    #1;
    chk("steer_addr_d", mem_req_msg.addr, 32'h1000);
    tick();
    dmem_req_val = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg.data = 32'hAA;
    #1;
    chk("steer_imem_val",  32'(imem_resp_val), 32'd1);
    chk("steer_imem_data", imem_resp_msg.data, 32'hAA);
    chk("steer_dmem_val0", 32'(dmem_resp_val), 32'd0);
    tick();
    mem_resp_msg.data = 32'hBB;
    #1;
    chk("steer_dmem_val",  32'(dmem_resp_val), 32'd1);
    chk("steer_dmem_data", dmem_resp_msg.data, 32'hBB);
    chk("steer_imem_val0", 32'(imem_resp_val), 32'd0);
    tick();
    mem_resp_val = 1'b0;

    // Squash one of two outstanding fetches
    imem_req_val = 1'b1; imem_req_msg.addr = 32'h400;
    tick();
    imem_req_msg.addr = 32'h404;
    tick();
    imem_req_val = 1'b0;
    imem_drop = 1'b1;
    tick();
    imem_drop = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg.data = 32'h11;
    #1;
    chk("drop_imem_val", 32'(imem_resp_val), 32'd0);
    chk("drop_resp_rdy", 32'(mem_resp_rdy),  32'd1);
    tick();
    mem_resp_msg.data = 32'h22;
    #1;
    chk("drop_second_val",  32'(imem_resp_val), 32'd1);
    chk("drop_second_data", imem_resp_msg.data, 32'h22);
    tick();
    mem_resp_val = 1'b0;
    imem_req_val = 1'b1;
    tick();
    imem_req_val = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg.data = 32'h33;
    #1;
    chk("drop_cnt_zero", 32'(imem_resp_val), 32'd1);
    tick();
    mem_resp_val = 1'b0;

    // Consumer back-pressure holds the response
    imem_req_val = 1'b1;
    tick();
    imem_req_val = 1'b0;
    imem_resp_rdy = 1'b0;
    mem_resp_val = 1'b1; mem_resp_msg.data = 32'h44;
    #1;
    chk("hold_resp_rdy", 32'(mem_resp_rdy),  32'd0);
    chk("hold_imem_val", 32'(imem_resp_val), 32'd1);
    tick();
    #1;
    chk("hold2_resp_rdy", 32'(mem_resp_rdy), 32'd0);
    chk("hold2_data",     imem_resp_msg.data, 32'h44);
    imem_resp_rdy = 1'b1;
    #1;
    chk("hold_release_rdy", 32'(mem_resp_rdy), 32'd1);
    tick();
    #1;
    chk("empty_resp_rdy", 32'(mem_resp_rdy),  32'd0);
    chk("empty_imem_val", 32'(imem_resp_val), 32'd0);
    mem_resp_val = 1'b0;

    // Mid-operation reset with three fetches in flight
    imem_req_val = 1'b1;
    repeat (3) tick();
    dmem_req_val = 1'b1;
    mem_resp_val = 1'b1;
    reset = 1'b0;
    #1;
    chk("mrst_mem_req_val",  32'(mem_req_val),   32'd0);
    chk("mrst_imem_req_rdy", 32'(imem_req_rdy),  32'd0);
    chk("mrst_dmem_req_rdy", 32'(dmem_req_rdy),  32'd0);
    chk("mrst_mem_resp_rdy", 32'(mem_resp_rdy),  32'd0);
    chk("mrst_imem_resp_val",32'(imem_resp_val), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_dmem_rdy", 32'(dmem_req_rdy),  32'd1);
    chk("post_rst_imem_rdy", 32'(imem_req_rdy),  32'd0);
    chk("post_rst_resp_rdy", 32'(mem_resp_rdy),  32'd0);
    chk("post_rst_imem_val", 32'(imem_resp_val), 32'd0);
    tick();
    imem_req_val = 1'b0; dmem_req_val = 1'b0;
    tick();
    mem_resp_val = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
